// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Integer register file for the RV32I core with a pending-write scoreboard.
// Decode issues destinations and reads operands. Writeback writes results and
// clears busy bits. Each read port reports whether its register still waits on
// a producer. A same-cycle write can be forwarded to the readers, so a result
// completing this cycle counts as available.

module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 32,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   we,
   input  logic [AW-1:0]          waddr,
   input  logic [XLEN-1:0]        wdata,
   input  logic                   issue_en,
   input  logic [AW-1:0]          issue_addr,
   input  logic [NUM_RD*AW-1:0]   raddr,
   output logic [NUM_RD*XLEN-1:0] rdata,
   output logic [NUM_RD-1:0]      rbusy,
   output logic [DEPTH-1:0]       busy_vec
);

   localparam bit ZeroOn   = (ZERO_REG != 0);
   localparam bit BypassOn = (BYPASS != 0);

   // Storage and scoreboard state
   logic [XLEN-1:0]  mem [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_next;

   // Per-register set/clear requests for this cycle
   logic [DEPTH-1:0] set_vec;
   logic [DEPTH-1:0] clr_vec;

   // A write to register 0 is thrown away when register 0 is hardwired to zero.
   // Only writes that are kept may update storage or feed the bypass path.
   logic write_ok;
   assign write_ok = we && !(ZeroOn && (waddr == '0));

   // Decode the issue and writeback addresses into one-hot request vectors.
   // The busy bit of the target register is set by issue_en and cleared by we.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int r = 0; r < DEPTH; r++) begin
         set_vec[r] = issue_en && (issue_addr == AW'(r));
         clr_vec[r] = we && (waddr == AW'(r));
      end
   end

   // Next scoreboard state. When a register is issued and written back in the
   // same cycle, the set wins. The new producer replaces the one that is
   // completing, so the register stays busy. Register 0 is never busy when it
   // is hardwired.
   always_comb begin
      busy_next = busy;
      for (int r = 0; r < DEPTH; r++) begin
         if (set_vec[r]) begin
            busy_next[r] = 1'b1;
         end else if (clr_vec[r]) begin
            busy_next[r] = 1'b0;
         end
      end
      if (ZeroOn) begin
         busy_next[0] = 1'b0;
      end
   end

   // Scoreboard register. An asynchronous reset clears every pending write at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   // Register storage. Reset zeroes every entry at once. Writes that arrive
   // while in reset never reach this block, so they are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DEPTH; r++) begin
            mem[r] <= '0;
         end
      end else if (write_ok) begin
         mem[waddr] <= wdata;
      end
   end

   // The debug/hazard view shows the registered bits only, with no forwarding.
   assign busy_vec = busy;

   // Independent combinational read ports
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0]   addr;
      logic            hit;
      logic [XLEN-1:0] port_data;
      logic            port_busy;

      assign addr = raddr[i*AW +: AW];
      assign hit  = BypassOn && write_ok && (waddr == addr);

      // Choose the read data. Reset and the hardwired zero register force 0.
      // These take priority over the bypass path.
      always_comb begin
         port_data = mem[addr];
         if (!rst_n) begin
            port_data = '0;
         end else if (ZeroOn && (addr == '0)) begin
            port_data = '0;
         end else if (hit) begin
            port_data = wdata;
         end
      end

      // A register whose producer completes this cycle counts as ready when
      // bypass is enabled. If the same register is also issued again this
      // cycle, it stays busy.
      always_comb begin
         port_busy = busy[addr];
         if (!rst_n) begin
            port_busy = 1'b0;
         end else if (BypassOn && clr_vec[addr] && !set_vec[addr]) begin
            port_busy = 1'b0;
         end
      end

      assign rdata[i*XLEN +: XLEN] = port_data;
      assign rbusy[i]              = port_busy;
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
// Directed bench for regfile_scoreboard. It drives three instances:
//   dut_a : default build (XLEN 32, DEPTH 32, 2 ports, zero reg, bypass)
//   dut_b : same inputs as dut_a, but r0 is an ordinary register and bypass is off
//   dut_c : wide build (XLEN 64, DEPTH 16, 4 ports)

module tb_regfile_scoreboard;

   logic clk;
   logic rst_n;

   // Shared stimulus for dut_a / dut_b
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        issue_en;
   logic [4:0]  issue_addr;
   logic [9:0]  raddr;

   logic [63:0] a_rdata;
   logic [1:0]  a_rbusy;
   logic [31:0] a_busy_vec;
   logic [63:0] b_rdata;
   logic [1:0]  b_rbusy;
   logic [31:0] b_busy_vec;

   // Stimulus for dut_c
   logic         c_we;
   logic [3:0]   c_waddr;
   logic [63:0]  c_wdata;
   logic         c_issue_en;
   logic [3:0]   c_issue_addr;
   logic [15:0]  c_raddr;
   logic [255:0] c_rdata;
   logic [3:0]   c_rbusy;
   logic [15:0]  c_busy_vec;

   int total;
   int bad;

   regfile_scoreboard #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .issue_en(issue_en), .issue_addr(issue_addr), .raddr(raddr),
      .rdata(a_rdata), .rbusy(a_rbusy), .busy_vec(a_busy_vec)
   );

   regfile_scoreboard #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .issue_en(issue_en), .issue_addr(issue_addr), .raddr(raddr),
      .rdata(b_rdata), .rbusy(b_rbusy), .busy_vec(b_busy_vec)
   );

   regfile_scoreboard #(.XLEN(64), .DEPTH(16), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
      .issue_en(c_issue_en), .issue_addr(c_issue_addr), .raddr(c_raddr),
      .rdata(c_rdata), .rbusy(c_rbusy), .busy_vec(c_busy_vec)
   );

   // 10 ns clock; rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Return the shared inputs to an idle state
   task automatic applyStimulus();
      we         = 1'b0;
      waddr      = '0;
      wdata      = '0;
      issue_en   = 1'b0;
      issue_addr = '0;
   endtask

   task automatic test_reset();
      // Drop rst_n while the clock runs. Present a write and an issue, which must be dropped.
      #1 rst_n = 1'b0;
      @(negedge clk);
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      issue_en = 1'b1; issue_addr = 5'd5;
      raddr = {5'd5, 5'd5};
      #1;
      total++; if (a_rdata !== 64'h0) begin bad++; $display("[TB] FAIL rst_rdata got=%h want=%h", a_rdata, 64'h0); end
      total++; if (a_rbusy !== 2'b00) begin bad++; $display("[TB] FAIL rst_rbusy got=%b want=%b", a_rbusy, 2'b00); end
      @(posedge clk); #1;
      total++; if (a_busy_vec !== 32'h0) begin bad++; $display("[TB] FAIL rst_busy_vec got=%h want=%h", a_busy_vec, 32'h0); end
      @(negedge clk);
      applyStimulus();
      rst_n = 1'b1;
      #1;
      total++; if (a_rdata[31:0] !== 32'h0) begin bad++; $display("[TB] FAIL rst_write_dropped got=%h want=%h", a_rdata[31:0], 32'h0); end
      // Normal write to r5, with an issue to r6
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      issue_en = 1'b1; issue_addr = 5'd6;
      @(posedge clk); #1;
      applyStimulus();
      #1;
      total++; if (a_rdata[31:0] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL r5_written got=%h want=%h", a_rdata[31:0], 32'hDEADBEEF); end
      total++; if (a_busy_vec !== 32'h0000_0040) begin bad++; $display("[TB] FAIL r6_busy got=%h want=%h", a_busy_vec, 32'h40); end
      // Assert reset asynchronously, mid-cycle
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++; if (a_rdata[31:0] !== 32'h0) begin bad++; $display("[TB] FAIL async_rst_rdata got=%h want=%h", a_rdata[31:0], 32'h0); end
      total++; if (a_busy_vec !== 32'h0) begin bad++; $display("[TB] FAIL async_rst_busy got=%h want=%h", a_busy_vec, 32'h0); end
      total++; if (b_busy_vec !== 32'h0) begin bad++; $display("[TB] FAIL async_rst_busy_b got=%h want=%h", b_busy_vec, 32'h0); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (a_rdata[31:0] !== 32'h0) begin bad++; $display("[TB] FAIL r5_cleared got=%h want=%h", a_rdata[31:0], 32'h0); end
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
      issue_en = 1'b1; issue_addr = 5'd0;
      raddr = {5'd0, 5'd0};
      #1;
      total++; if (a_rdata[31:0] !== 32'h0) begin bad++; $display("[TB] FAIL zero_bypass got=%h want=%h", a_rdata[31:0], 32'h0); end
      @(posedge clk); #1;
      total++; if (a_rdata[31:0] !== 32'h0) begin bad++; $display("[TB] FAIL zero_read got=%h want=%h", a_rdata[31:0], 32'h0); end
      total++; if (a_busy_vec !== 32'h0) begin bad++; $display("[TB] FAIL zero_busy got=%h want=%h", a_busy_vec, 32'h0); end
      total++; if (b_rdata[31:0] !== 32'h1234) begin bad++; $display("[TB] FAIL r0_ordinary got=%h want=%h", b_rdata[31:0], 32'h1234); end
      total++; if (b_busy_vec !== 32'h1) begin bad++; $display("[TB] FAIL r0_ordinary_busy got=%h want=%h", b_busy_vec, 32'h1); end
      applyStimulus();
   endtask

   task automatic test_bypass();
      @(negedge clk);
      we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
      raddr = {5'd7, 5'd0};
      @(posedge clk);
      @(negedge clk);
      wdata = 32'hA5A5A5A5;
      #1;
      total++; if (a_rdata[63:32] !== 32'hA5A5A5A5) begin bad++; $display("[TB] FAIL bypass_on got=%h want=%h", a_rdata[63:32], 32'hA5A5A5A5); end
      total++; if (b_rdata[63:32] !== 32'h11111111) begin bad++; $display("[TB] FAIL bypass_off got=%h want=%h", b_rdata[63:32], 32'h11111111); end
      @(posedge clk); #1;
      total++; if (b_rdata[63:32] !== 32'hA5A5A5A5) begin bad++; $display("[TB] FAIL bypass_off_after got=%h want=%h", b_rdata[63:32], 32'hA5A5A5A5); end
      applyStimulus();
   endtask

   task automatic test_scoreboard();
      @(negedge clk);
      issue_en = 1'b1; issue_addr = 5'd3;
      raddr = {5'd7, 5'd3};
      @(posedge clk);
      @(negedge clk);
      applyStimulus();
      #1;
      total++; if (a_busy_vec[3] !== 1'b1) begin bad++; $display("[TB] FAIL sb_set got=%b want=%b", a_busy_vec[3], 1'b1); end
      total++; if (a_rbusy !== 2'b01) begin bad++; $display("[TB] FAIL sb_rbusy got=%b want=%b", a_rbusy, 2'b01); end
      @(negedge clk);
      we = 1'b1; waddr = 5'd3; wdata = 32'h55;
      #1;
      total++; if (a_rbusy[0] !== 1'b0) begin bad++; $display("[TB] FAIL sb_rbusy_bypass got=%b want=%b", a_rbusy[0], 1'b0); end
      total++; if (a_rdata[31:0] !== 32'h55) begin bad++; $display("[TB] FAIL sb_rdata got=%h want=%h", a_rdata[31:0], 32'h55); end
      total++; if (b_rbusy[0] !== 1'b1) begin bad++; $display("[TB] FAIL sb_rbusy_nobypass got=%b want=%b", b_rbusy[0], 1'b1); end
      total++; if (a_busy_vec[3] !== 1'b1) begin bad++; $display("[TB] FAIL sb_busy_vec_registered got=%b want=%b", a_busy_vec[3], 1'b1); end
      @(posedge clk); #1;
      total++; if (a_busy_vec[3] !== 1'b0) begin bad++; $display("[TB] FAIL sb_clear got=%b want=%b", a_busy_vec[3], 1'b0); end
      total++; if (b_busy_vec[3] !== 1'b0) begin bad++; $display("[TB] FAIL sb_clear_b got=%b want=%b", b_busy_vec[3], 1'b0); end
      applyStimulus();
   endtask

   task automatic test_collision();
      @(negedge clk);
      issue_en = 1'b1; issue_addr = 5'd9;
      raddr = {5'd0, 5'd9};
      @(posedge clk);
      @(negedge clk);
      we = 1'b1; waddr = 5'd9; wdata = 32'h99;
      #1;
      total++; if (a_rbusy[0] !== 1'b1) begin bad++; $display("[TB] FAIL coll_rbusy got=%b want=%b", a_rbusy[0], 1'b1); end
      total++; if (a_rdata[31:0] !== 32'h99) begin bad++; $display("[TB] FAIL coll_bypass got=%h want=%h", a_rdata[31:0], 32'h99); end
      @(posedge clk); #1;
      total++; if (a_busy_vec !== 32'h0000_0200) begin bad++; $display("[TB] FAIL coll_busy got=%h want=%h", a_busy_vec, 32'h200); end
      total++; if (b_busy_vec !== 32'h0000_0201) begin bad++; $display("[TB] FAIL coll_busy_b got=%h want=%h", b_busy_vec, 32'h201); end
      applyStimulus();
      #1;
      total++; if (a_rdata[31:0] !== 32'h99) begin bad++; $display("[TB] FAIL coll_mem got=%h want=%h", a_rdata[31:0], 32'h99); end
      total++; if (a_rbusy[0] !== 1'b1) begin bad++; $display("[TB] FAIL coll_rbusy_after got=%b want=%b", a_rbusy[0], 1'b1); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         we = 1'b1; waddr = 5'(10 + k); wdata = 32'h1000 + 32'(k);
         raddr = {5'(10 + k), 5'(9 + k)};
         #1;
         total++; if (a_rdata[63:32] !== 32'h1000 + 32'(k)) begin bad++; $display("[TB] FAIL b2b_new k=%0d got=%h want=%h", k, a_rdata[63:32], 32'h1000 + 32'(k)); end
         if (k > 0) begin
            total++; if (a_rdata[31:0] !== 32'h1000 + 32'(k - 1)) begin bad++; $display("[TB] FAIL b2b_prev k=%0d got=%h want=%h", k, a_rdata[31:0], 32'h1000 + 32'(k - 1)); end
         end
         @(posedge clk);
      end
      @(negedge clk);
      applyStimulus();
      raddr = {5'd13, 5'd10};
      #1;
      total++; if (a_rdata !== {32'h1003, 32'h1000}) begin bad++; $display("[TB] FAIL b2b_final got=%h want=%h", a_rdata, {32'h1003, 32'h1000}); end
   endtask

   task automatic test_port_scaling();
      logic [63:0] model [16];
      int          tbl [4][4];
      tbl = '{'{0, 5, 5, 15}, '{3, 3, 3, 3}, '{9, 1, 14, 0}, '{15, 8, 7, 2}};
      for (int r = 0; r < 16; r++) begin
         @(negedge clk);
         c_we = 1'b1; c_waddr = 4'(r);
         c_wdata = 64'h0123_4567_89AB_CDEF ^ (64'h1111_1111_1111_1111 * 64'(r));
         model[r] = (r == 0) ? 64'h0 : c_wdata;
         @(posedge clk);
      end
      @(negedge clk);
      c_we = 1'b0;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         c_raddr = {4'(tbl[t][3]), 4'(tbl[t][2]), 4'(tbl[t][1]), 4'(tbl[t][0])};
         #1;
         for (int p = 0; p < 4; p++) begin
            total++;
            if (c_rdata[p*64 +: 64] !== model[tbl[t][p]]) begin
               bad++;
               $display("[TB] FAIL wide_read t=%0d port=%0d got=%h want=%h", t, p, c_rdata[p*64 +: 64], model[tbl[t][p]]);
            end
         end
      end
      total++; if (c_busy_vec !== 16'h0) begin bad++; $display("[TB] FAIL wide_busy got=%h want=%h", c_busy_vec, 16'h0); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b1;
      applyStimulus();
      raddr        = '0;
      c_we         = 1'b0;
      c_waddr      = '0;
      c_wdata      = '0;
      c_issue_en   = 1'b0;
      c_issue_addr = '0;
      c_raddr      = '0;
      test_reset();
      test_zero_reg();
      test_bypass();
      test_scoreboard();
      test_collision();
      test_back_to_back();
      test_port_scaling();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
